// File: rtl/cap_touch_scanner.sv
// Capacitive pad scanner: RC charge timing, threshold, debounce and sticky hits
// for the whack-a-mole front end.
module cap_touch_scanner #(
   parameter int NUM_PADS         = 9,
   parameter int CNT_W            = 12,
   parameter int DISCHARGE_CYCLES = 1000,
   parameter int TIMEOUT          = 4095,
   parameter int THRESH           = 200,
   parameter int DEBOUNCE         = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_PADS-1:0] capacitive_sensors_in,
   output logic                capacitive_sensors_out,
   output logic [NUM_PADS-1:0] touched,
   output logic [NUM_PADS-1:0] hit_pending,
   input  logic [NUM_PADS-1:0] hit_clear,
   output logic                scan_done,
   output logic [CNT_W-1:0]    last_time
);

   localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TH       = CNT_W'(THRESH);
   localparam logic [2:0]       DEB      = 3'(DEBOUNCE);

   typedef enum logic [1:0] {
      DISCHARGE,
      CHARGE,
      EVAL
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_PADS-1:0]  meta_q, sync_q;
   logic [CNT_W-1:0]     cap_q [NUM_PADS];
   logic [CNT_W-1:0]     cap_d [NUM_PADS];
   logic [NUM_PADS-1:0]  capd_q, capd_d;
   logic [2:0]           dc_q [NUM_PADS];
   logic [2:0]           dc_d [NUM_PADS];
   logic [NUM_PADS-1:0]  touched_q, touched_d;
   logic [NUM_PADS-1:0]  hit_q, hit_d;
   logic [NUM_PADS-1:0]  raw, set_mask;
   logic                 done_q, done_d;
   logic                 drive_q, drive_d;
   logic [CNT_W-1:0]     last_q, last_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capd_d    = capd_q;
      touched_d = touched_q;
      done_d    = 1'b0;
      last_d    = last_q;
      raw       = '0;
      set_mask  = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         cap_d[i] = cap_q[i];
         dc_d[i]  = dc_q[i];
      end
      unique case (state_q)
         DISCHARGE: begin
            if (cnt_q == DIS_LAST) begin
               cnt_d   = '0;
               capd_d  = '0;
               state_d = CHARGE;
               // Preload timeout so pads that never rise read as TIMEOUT
               for (int i = 0; i < NUM_PADS; i++) cap_d[i] = TMO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CHARGE: begin
            for (int i = 0; i < NUM_PADS; i++) begin
               if (!capd_q[i] && sync_q[i]) begin
                  cap_d[i]  = cnt_q;
                  capd_d[i] = 1'b1;
               end
            end
            if ((&capd_d) || (cnt_q == TMO)) begin
               cnt_d   = '0;
               state_d = EVAL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         EVAL: begin
            for (int i = 0; i < NUM_PADS; i++) begin
               raw[i] = (cap_q[i] >= TH);
               if (raw[i] == touched_q[i]) begin
                  dc_d[i] = '0;
               end else if (dc_q[i] + 3'd1 == DEB) begin
                  touched_d[i] = raw[i];
                  dc_d[i]      = '0;
                  set_mask[i]  = raw[i];
               end else begin
                  dc_d[i] = dc_q[i] + 3'd1;
               end
            end
            done_d  = 1'b1;
            last_d  = cap_q[0];
            cnt_d   = '0;
            state_d = DISCHARGE;
         end
         default: begin
            cnt_d   = '0;
            state_d = DISCHARGE;
         end
      endcase
      // A new hit outranks a clear landing on the same cycle
      hit_d   = (hit_q & ~hit_clear) | set_mask;
      drive_d = (state_d == CHARGE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= DISCHARGE;
         cnt_q     <= '0;
         meta_q    <= '0;
         sync_q    <= '0;
         capd_q    <= '0;
         touched_q <= '0;
         hit_q     <= '0;
         done_q    <= 1'b0;
         drive_q   <= 1'b0;
         last_q    <= '0;
         for (int i = 0; i < NUM_PADS; i++) begin
            cap_q[i] <= '0;
            dc_q[i]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         meta_q    <= capacitive_sensors_in;
         sync_q    <= meta_q;
         capd_q    <= capd_d;
         touched_q <= touched_d;
         hit_q     <= hit_d;
         done_q    <= done_d;
         drive_q   <= drive_d;
         last_q    <= last_d;
         for (int i = 0; i < NUM_PADS; i++) begin
            cap_q[i] <= cap_d[i];
            dc_q[i]  <= dc_d[i];
         end
      end
   end

   assign capacitive_sensors_out = drive_q;
   assign touched                = touched_q;
   assign hit_pending            = hit_q;
   assign scan_done              = done_q;
   assign last_time              = last_q;

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Scoreboard bench for cap_touch_scanner: pads modelled as RC rise delays
// relative to the charge line, results checked at each scan_done.
module tb_cap_touch_scanner;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [8:0] pads = '0;
   logic [8:0] hit_clear = '0;
   logic       so;
   logic [8:0] touched;
   logic [8:0] hit_pending;
   logic       scan_done;
   logic [7:0] last_time;

   cap_touch_scanner #(
      .NUM_PADS(9), .CNT_W(8), .DISCHARGE_CYCLES(4),
      .TIMEOUT(63), .THRESH(20), .DEBOUNCE(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .capacitive_sensors_in(pads),
      .capacitive_sensors_out(so),
      .touched(touched),
      .hit_pending(hit_pending),
      .hit_clear(hit_clear),
      .scan_done(scan_done),
      .last_time(last_time)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [8:0] t;
      logic [8:0] h;
      logic [7:0] lt;
      int         len;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   rise[9];
   int   k = 0;
   int   charge_len = 0;
   int   scan_no = 0;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (scan %0d): got %0h expected %0h",
                  name, scan_no, act, exp);
      end
   endfunction

   // Pad i goes high rise[i] cycles after the charge line rises.
   always @(negedge clock) begin
      if (so) begin
         for (int i = 0; i < 9; i++) pads[i] = (k >= rise[i]);
         k++;
      end else begin
         if (k != 0) charge_len = k;
         k = 0;
         pads = '0;
      end
   end

   always @(negedge clock) begin
      if (scan_done === 1'b1) begin
         scan_no++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_scan_done: got 1 expected 0");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("touched", 32'(touched), 32'(e.t));
            chk("hit_pending", 32'(hit_pending), 32'(e.h));
            chk("last_time", 32'(last_time), 32'(e.lt));
            chk("charge_len", 32'(charge_len), 32'(e.len));
         end
      end
   end

   task automatic scan(input int r0, input int r3, input logic [8:0] et,
                       input logic [8:0] eh, input logic [7:0] el,
                       input int len, input bit clr_eval);
      bit got;
      bit prev;
      exp_t e;
      for (int i = 0; i < 9; i++) rise[i] = 5;
      rise[0] = r0;
      rise[3] = r3;
      e.t = et; e.h = eh; e.lt = el; e.len = len;
      q.push_back(e);
      got = 1'b0;
      prev = so;
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         hit_clear = '0;
         if (clr_eval && prev && !so) hit_clear = 9'h008;
         if (scan_done) begin
            if (clr_eval) hit_clear = 9'h008;
            got = 1'b1;
            break;
         end
         prev = so;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL scan_timeout: got no scan_done expected one");
      end
   endtask

   task automatic count_discharge();
      int lowc;
      lowc = 0;
      for (int n = 0; n < 50; n++) begin
         @(posedge clock);
         #1;
         lowc++;
         if (so) break;
      end
      chk("discharge_len", 32'(lowc), 32'd4);
   endtask

   initial begin
      for (int i = 0; i < 9; i++) rise[i] = 5;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_sensors_out", 32'(so), 32'd0);
      chk("rst_touched", 32'(touched), 32'd0);
      chk("rst_hit", 32'(hit_pending), 32'd0);
      chk("rst_scan_done", 32'(scan_done), 32'd0);
      chk("rst_last_time", 32'(last_time), 32'd0);
      reset = 1'b1;
      count_discharge();

      scan(5, 5, 9'h000, 9'h000, 8'd7, 8, 1'b0);
      scan(10, 5, 9'h000, 9'h000, 8'd12, 13, 1'b0);
      scan(5, 30, 9'h000, 9'h000, 8'd7, 33, 1'b0);
      scan(5, 30, 9'h008, 9'h008, 8'd7, 33, 1'b0);
      scan(5, 5, 9'h008, 9'h008, 8'd7, 8, 1'b0);
      scan(5, 5, 9'h000, 9'h008, 8'd7, 8, 1'b0);
      hit_clear = 9'h008;
      @(negedge clock);
      hit_clear = '0;
      chk("clear_idle_hit", 32'(hit_pending), 32'd0);
      chk("clear_idle_touched", 32'(touched), 32'd0);

      scan(5, 255, 9'h000, 9'h000, 8'd7, 64, 1'b0);
      scan(5, 255, 9'h008, 9'h008, 8'd7, 64, 1'b1);
      @(negedge clock);
      hit_clear = '0;
      chk("clear_late_hit", 32'(hit_pending), 32'd0);
      chk("clear_late_touched", 32'(touched), 32'h008);

      scan(5, 5, 9'h008, 9'h000, 8'd7, 8, 1'b0);
      scan(5, 5, 9'h000, 9'h000, 8'd7, 8, 1'b0);
      scan(5, 30, 9'h000, 9'h000, 8'd7, 33, 1'b0);
      scan(5, 5, 9'h000, 9'h000, 8'd7, 8, 1'b0);
      scan(5, 30, 9'h000, 9'h000, 8'd7, 33, 1'b0);
      scan(5, 30, 9'h008, 9'h008, 8'd7, 33, 1'b0);
      scan(5, 5, 9'h008, 9'h008, 8'd7, 8, 1'b0);
      scan(5, 5, 9'h000, 9'h008, 8'd7, 8, 1'b0);
      scan(5, 30, 9'h000, 9'h008, 8'd7, 33, 1'b0);
      scan(5, 30, 9'h008, 9'h008, 8'd7, 33, 1'b0);

      rise[3] = 30;
      for (int n = 0; n < 50; n++) begin
         @(negedge clock);
         if (so) break;
      end
      chk("abort_in_charge", 32'(so), 32'd1);
      repeat (10) @(negedge clock);
      chk("pre_abort_touched", 32'(touched), 32'h008);
      chk("pre_abort_hit", 32'(hit_pending), 32'h008);
      reset = 1'b0;
      @(negedge clock);
      chk("abort_sensors_out", 32'(so), 32'd0);
      chk("abort_touched", 32'(touched), 32'd0);
      chk("abort_hit", 32'(hit_pending), 32'd0);
      chk("abort_scan_done", 32'(scan_done), 32'd0);
      chk("abort_last_time", 32'(last_time), 32'd0);
      for (int i = 0; i < 9; i++) rise[i] = 5;
      @(negedge clock);
      reset = 1'b1;
      count_discharge();
      scan(5, 5, 9'h000, 9'h000, 8'd7, 8, 1'b0);

      repeat (2) @(negedge clock);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
